alu_seq_responder: RTL and testbench

- Multi-cycle ALU request/response server: accepts {A, B, cmd} over a valid/ready request port and returns {result, carryout, zero, overflow} over a valid/ready response port.
- Same 3-bit command encoding and flag semantics as the team's combinational ALU.
- Evaluates in CHUNK-bit slices, one slice per clock, with a registered carry chain between slices.
- Serves as the hardware-side responder that stimulus engines and the CPU datapath issue operations to.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_slice.sv | 36 +++
 rtl/alu_seq_responder.sv | 147 ++++++++++++++
 tb/tb_alu_seq_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU responder: command and FSM state encodings,
// default geometry.
package alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CHUNK_DEF = 8;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_SLT  = 3'd2,
        CMD_XOR  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_arith(alu_cmd_t c);
        return (c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_SLT);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational CHUNK-bit ALU slice; carries in/out so a wide operation can be
// walked one slice per cycle.
module alu_slice
    import alu_pkg::*;
#(
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  alu_cmd_t         cmd,
    input  logic             cin,
    output logic [CHUNK-1:0] y,
    output logic             cout,
    output logic             msb_cin
);

    logic [CHUNK-1:0] bx;
    logic [CHUNK:0]   sum;

    always_comb begin
        bx      = (cmd == CMD_ADD) ? b : ~b;
        sum     = {1'b0, a} + {1'b0, bx} + {{CHUNK{1'b0}}, cin};
        cout    = sum[CHUNK];
        // carry into the slice MSB, recovered from the sum bit
        msb_cin = sum[CHUNK-1] ^ a[CHUNK-1] ^ bx[CHUNK-1];
        unique case (cmd)
            CMD_XOR:  y = a ^ b;
            CMD_AND:  y = a & b;
            CMD_NAND: y = ~(a & b);
            CMD_NOR:  y = ~(a | b);
            CMD_OR:   y = a | b;
            default:  y = sum[CHUNK-1:0];
        endcase
    end

endmodule

// File: rtl/alu_seq_responder.sv
// Multi-cycle ALU request/response server evaluating CHUNK bits per clock.
// Optional: ALU_SEQ_LOGIC_BYPASS_EN makes logic commands complete in one cycle.
module alu_seq_responder
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_cmd,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carryout,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             busy
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("alu_seq_responder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, work_q, work_d, final_res;
    alu_cmd_t         cmd_q, cmd_in;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic             last;
    logic [CHUNK-1:0] s_y;
    logic             s_cout, s_msb_cin, slt_bit;

    assign cmd_in    = alu_cmd_t'(req_cmd);
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign last      = (idx_q == IW'(N - 1));

    alu_slice #(.CHUNK(CHUNK)) u_slice (
        .a       (a_q[idx_q*CHUNK +: CHUNK]),
        .b       (b_q[idx_q*CHUNK +: CHUNK]),
        .cmd     (cmd_q),
        .cin     (carry_q),
        .y       (s_y),
        .cout    (s_cout),
        .msb_cin (s_msb_cin)
    );

    always_comb begin
        work_d = work_q;
        work_d[idx_q*CHUNK +: CHUNK] = s_y;
        // less-than is sign XOR overflow of A-B, valid only on the top slice
        slt_bit   = s_y[CHUNK-1] ^ (s_msb_cin ^ s_cout);
        final_res = (cmd_q == CMD_SLT) ? {{(WIDTH-1){1'b0}}, slt_bit} : work_d;
    end

`ifdef ALU_SEQ_LOGIC_BYPASS_EN
    logic [WIDTH-1:0] logic_res;

    always_comb begin
        logic_res = '0;
        case (cmd_in)
            CMD_XOR:  logic_res = req_a ^ req_b;
            CMD_AND:  logic_res = req_a & req_b;
            CMD_NAND: logic_res = ~(req_a & req_b);
            CMD_NOR:  logic_res = ~(req_a | req_b);
            CMD_OR:   logic_res = req_a | req_b;
            default:  logic_res = '0;
        endcase
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) begin
`ifdef ALU_SEQ_LOGIC_BYPASS_EN
                state_d = is_arith(cmd_in) ? ST_EXEC : ST_DONE;
`else
                state_d = ST_EXEC;
`endif
            end
            ST_EXEC: if (last) state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            work_q       <= '0;
            cmd_q        <= CMD_ADD;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            rsp_result   <= '0;
            rsp_carryout <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    a_q     <= req_a;
                    b_q     <= req_b;
                    cmd_q   <= cmd_in;
                    carry_q <= (cmd_in == CMD_SUB) || (cmd_in == CMD_SLT);
                    idx_q   <= '0;
`ifdef ALU_SEQ_LOGIC_BYPASS_EN
                    if (!is_arith(cmd_in)) begin
                        rsp_result   <= logic_res;
                        rsp_zero     <= (logic_res == '0);
                        rsp_carryout <= 1'b0;
                        rsp_overflow <= 1'b0;
                    end
`endif
                end
                ST_EXEC: begin
                    work_q  <= work_d;
                    carry_q <= s_cout;
                    idx_q   <= last ? '0 : idx_q + 1'b1;
                    if (last) begin
                        rsp_result   <= final_res;
                        rsp_zero     <= (final_res == '0);
                        rsp_carryout <= ((cmd_q == CMD_ADD) || (cmd_q == CMD_SUB)) & s_cout;
                        rsp_overflow <= ((cmd_q == CMD_ADD) || (cmd_q == CMD_SUB)) &
                                        (s_msb_cin ^ s_cout);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_responder.sv
// Directed table-driven bench for alu_seq_responder plus backpressure and reset sequences.
module tb_alu_seq_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req_a, req_b, rsp_result;
    logic [2:0]  req_cmd;
    logic        rsp_carryout, rsp_zero, rsp_overflow, busy;

    int checks   = 0;
    int failures = 0;

    alu_seq_responder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  cmd;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] cmd);
`ifdef ALU_SEQ_LOGIC_BYPASS_EN
        return (cmd >= 3'd3) ? 1 : 4;
`else
        return 4;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for its response; leaves rsp_ready low, response pending.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd,
                         output int lat);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin tick(); w++; end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
        req_a = a; req_b = b; req_cmd = cmd; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin tick(); lat++; end
        if (!rsp_valid) check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic seen;
        vecs[0]  = '{32'hB0000000, 32'hA0000000, 3'd0, 32'h50000000, 1, 0, 1};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 32'h00000000, 1, 1, 0};
        vecs[2]  = '{32'h70000000, 32'hA0000000, 3'd1, 32'hD0000000, 0, 0, 1};
        vecs[3]  = '{32'hC0000000, 32'h90000000, 3'd2, 32'h00000000, 0, 1, 0};
        vecs[4]  = '{32'hA0000000, 32'hD0000000, 3'd2, 32'h00000001, 0, 0, 0};
        vecs[5]  = '{32'h00000000, 32'h00000000, 3'd6, 32'hFFFFFFFF, 0, 0, 0};
        vecs[6]  = '{32'h0F0F0F0F, 32'hFF00FF00, 3'd3, 32'hF00FF00F, 0, 0, 0};
        vecs[7]  = '{32'hFFFF0000, 32'h12345678, 3'd4, 32'h12340000, 0, 0, 0};
        vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5, 32'h00000000, 0, 1, 0};
        vecs[9]  = '{32'h00000000, 32'h00000000, 3'd7, 32'h00000000, 0, 1, 0};
        vecs[10] = '{32'h7FFFFFFF, 32'h00000001, 3'd0, 32'h80000000, 0, 0, 1};
        vecs[11] = '{32'hFFFFFFFF, 32'h00000001, 3'd0, 32'h00000000, 1, 1, 0};
        vecs[12] = '{32'h80000000, 32'h00000001, 3'd2, 32'h00000001, 0, 0, 0};
        vecs[13] = '{32'h00000005, 32'h00000007, 3'd1, 32'hFFFFFFFE, 0, 0, 0};

        reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_cmd = '0;
        repeat (3) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_flags", {29'd0, rsp_carryout, rsp_zero, rsp_overflow}, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cmd, lat);
            check($sformatf("v%0d_result", i), rsp_result, vecs[i].res);
            check($sformatf("v%0d_carry", i), 32'(rsp_carryout), 32'(vecs[i].c));
            check($sformatf("v%0d_zero", i), 32'(rsp_zero), 32'(vecs[i].z));
            check($sformatf("v%0d_ovf", i), 32'(rsp_overflow), 32'(vecs[i].o));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].cmd)));
            release_rsp();
        end

        // Backpressure: response held while the next request waits at the port.
        issue(32'h12345678, 32'h11111111, 3'd0, lat);
        req_a = 32'h0000FFFF; req_b = 32'h00FF00FF; req_cmd = 3'd3; req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_result", rsp_result, 32'h23456789);
        end
        release_rsp();
        check("bp_idle_ready", 32'(req_ready), 32'd1);
        check("bp_idle_busy", 32'(busy), 32'd0);
        tick();
        req_valid = 1'b0;
        check("bp_accept_busy", 32'(busy), 32'd1);
        lat = 0;
        while (!rsp_valid && lat < 20) begin tick(); lat++; end
        check("bp_next_result", rsp_result, 32'h00FFFF00);
        release_rsp();

        // Reset two EXEC cycles into an add; the in-flight request must vanish.
        req_a = 32'h11111111; req_b = 32'h22222222; req_cmd = 3'd0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("mid_busy_before_reset", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_reset_rsp_result", rsp_result, 32'd0);
        check("mid_reset_flags", {29'd0, rsp_carryout, rsp_zero, rsp_overflow}, 32'd0);
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        check("mid_reset_no_rsp", 32'(seen), 32'd0);
        issue(32'h00000001, 32'h00000002, 3'd0, lat);
        check("post_reset_result", rsp_result, 32'h00000003);
        check("post_reset_latency", 32'(lat), 32'd4);
        release_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
